// File: rtl/mips_core_pkg.sv
// Shared core types reused by the branch target buffer.
// ADDR_WIDTH normally comes from mips_core.svh; a 32-bit default is supplied here when unset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        BTB_IDLE  = 1'b0,
        BTB_SWEEP = 1'b1
    } BtbState;

    localparam logic [1:0] BTB_CTR_INIT = 2'b10;

endpackage

// File: rtl/btb_sweep_fsm.sv
// Invalidation sweep sequencer for the branch target buffer: walks every index once,
// one per cycle, after a flush request while idle.
module btb_sweep_fsm
    import mips_core_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush_req,
    output logic                o_busy,
    output logic                clear_en,
    output logic [IDX_BITS-1:0] clear_idx
);

    BtbState             state;
    logic [IDX_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BTB_IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
        end else begin
            case (state)
                BTB_IDLE: begin
                    if (i_flush_req) begin
                        state  <= BTB_SWEEP;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                BTB_SWEEP: begin
                    // Counter wraps to 0 after the last index, ready for the next sweep.
                    cnt <= cnt + 1'b1;
                    if (cnt == IDX_BITS'(ENTRIES - 1)) begin
                        state  <= BTB_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= BTB_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clear_en  = (state == BTB_SWEEP);
    assign clear_idx = cnt;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped fetch-stage BTB: zero-latency lookup, trained by EX results, flushable by sweep.
// Optional per-entry 2-bit hysteresis counters are enabled by defining BTB_HYSTERESIS_EN.
module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_lookup_valid,
    input  logic [`ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                   o_hit,
    output logic                   o_pred_taken,
    output logic [`ADDR_WIDTH-1:0] o_pred_target,
    input  logic                   i_upd_valid,
    input  logic [`ADDR_WIDTH-1:0] i_upd_pc,
    input  BranchOutcome           i_upd_outcome,
    input  logic [`ADDR_WIDTH-1:0] i_upd_target,
    input  logic                   i_flush_req,
    output logic                   o_busy
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS = `ADDR_WIDTH - IDX_BITS - 2;

    logic [ENTRIES-1:0]     valid_q;
    logic [TAG_BITS-1:0]    tag_q    [ENTRIES];
    logic [`ADDR_WIDTH-1:0] target_q [ENTRIES];

    logic                clear_en;
    logic [IDX_BITS-1:0] clear_idx;

    btb_sweep_fsm #(
        .ENTRIES  (ENTRIES),
        .IDX_BITS (IDX_BITS)
    ) u_sweep (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush_req (i_flush_req),
        .o_busy      (o_busy),
        .clear_en    (clear_en),
        .clear_idx   (clear_idx)
    );

    logic [IDX_BITS-1:0] l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                u_hit, upd_en, upd_taken;
    logic                unused_pc_bits;

    assign l_idx = i_lookup_pc[IDX_BITS+1:2];
    assign l_tag = i_lookup_pc[`ADDR_WIDTH-1:IDX_BITS+2];
    assign u_idx = i_upd_pc[IDX_BITS+1:2];
    assign u_tag = i_upd_pc[`ADDR_WIDTH-1:IDX_BITS+2];
    assign unused_pc_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign u_hit     = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
    assign upd_en    = i_upd_valid & ~o_busy;
    assign upd_taken = (i_upd_outcome == TAKEN);

    assign o_hit         = i_lookup_valid & valid_q[l_idx] & (tag_q[l_idx] == l_tag) & ~o_busy;
    assign o_pred_target = o_hit ? target_q[l_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_en) begin
            valid_q[clear_idx] <= 1'b0;
        end else if (upd_en) begin
            if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
            end
`ifndef BTB_HYSTERESIS_EN
            else if (u_hit) begin
                valid_q[u_idx] <= 1'b0;
            end
`endif
        end
    end

    // Payload is meaningless while valid is clear, so it is left unreset.
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= i_upd_target;
        end
    end

`ifdef BTB_HYSTERESIS_EN
    logic [1:0] ctr_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (!u_hit) begin
                if (upd_taken) begin
                    ctr_q[u_idx] <= BTB_CTR_INIT;
                end
            end else if (upd_taken) begin
                if (ctr_q[u_idx] != 2'b11) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                end
            end else if (ctr_q[u_idx] != 2'b00) begin
                ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
            end
        end
    end

    assign o_pred_taken = o_hit & ctr_q[l_idx][1];
`else
    assign o_pred_taken = o_hit;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (64 entries, 32-bit addresses).
module tb_branch_target_buffer;
    import mips_core_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   i_lookup_valid;
    logic [`ADDR_WIDTH-1:0] i_lookup_pc;
    logic                   o_hit;
    logic                   o_pred_taken;
    logic [`ADDR_WIDTH-1:0] o_pred_target;
    logic                   i_upd_valid;
    logic [`ADDR_WIDTH-1:0] i_upd_pc;
    BranchOutcome           i_upd_outcome;
    logic [`ADDR_WIDTH-1:0] i_upd_target;
    logic                   i_flush_req;
    logic                   o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_lookup_valid (i_lookup_valid),
        .i_lookup_pc    (i_lookup_pc),
        .o_hit          (o_hit),
        .o_pred_taken   (o_pred_taken),
        .o_pred_target  (o_pred_target),
        .i_upd_valid    (i_upd_valid),
        .i_upd_pc       (i_upd_pc),
        .i_upd_outcome  (i_upd_outcome),
        .i_upd_target   (i_upd_target),
        .i_flush_req    (i_flush_req),
        .o_busy         (o_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input BranchOutcome oc, input logic [31:0] tgt);
        @(negedge clk);
        i_upd_valid   = 1'b1;
        i_upd_pc      = pc;
        i_upd_outcome = oc;
        i_upd_target  = tgt;
        @(posedge clk);
        #1 i_upd_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
        @(negedge clk);
        i_lookup_valid = 1'b1;
        i_lookup_pc    = pc;
        #1;
        check_eq({tag, "_hit"}, 32'(o_hit), 32'(hit));
        check_eq({tag, "_taken"}, 32'(o_pred_taken), 32'(taken));
        check_eq({tag, "_target"}, o_pred_target, tgt);
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        i_flush_req = 1'b1;
        @(posedge clk);
        #1 i_flush_req = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        i_lookup_valid = 1'b0;
        i_lookup_pc    = '0;
        i_upd_valid    = 1'b0;
        i_upd_pc       = '0;
        i_upd_outcome  = NOT_TAKEN;
        i_upd_target   = '0;
        i_flush_req    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        look("reset", 32'h0040_0100, 1'b0, 1'b0, 32'h0);
        check_eq("reset_busy", 32'(o_busy), 32'd0);

        // Allocate on taken
        upd(32'h0040_0100, TAKEN, 32'h0040_0080);
        look("alloc", 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0080);

        // Same index, new tag evicts
        upd(32'h0040_0200, TAKEN, 32'h0040_0300);
        look("alias_old", 32'h0040_0100, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h0040_0200, 1'b1, 1'b1, 32'h0040_0300);

        // Hysteresis / invalidation on not-taken
        upd(32'h0040_0200, NOT_TAKEN, 32'h0);
`ifdef BTB_HYSTERESIS_EN
        look("hyst_nt", 32'h0040_0200, 1'b1, 1'b0, 32'h0040_0300);
        upd(32'h0040_0200, TAKEN, 32'h0040_0300);
        look("hyst_t", 32'h0040_0200, 1'b1, 1'b1, 32'h0040_0300);
`else
        look("nohyst_nt", 32'h0040_0200, 1'b0, 1'b0, 32'h0);
`endif

        // Same-cycle update and lookup: no bypass
        @(negedge clk);
        i_upd_valid    = 1'b1;
        i_upd_pc       = 32'h0040_0404;
        i_upd_outcome  = TAKEN;
        i_upd_target   = 32'h0040_0500;
        i_lookup_valid = 1'b1;
        i_lookup_pc    = 32'h0040_0404;
        #1 check_eq("same_cycle_hit", 32'(o_hit), 32'd0);
        @(posedge clk);
        #1 i_upd_valid = 1'b0;
        look("next_cycle", 32'h0040_0404, 1'b1, 1'b1, 32'h0040_0500);

        // Fill four entries then sweep
        for (int i = 0; i < 4; i++) begin
            upd(32'h0040_0010 + 32'(4 * i), TAKEN, 32'h0040_1000 + 32'(i));
        end
        look("fill_chk", 32'h0040_001C, 1'b1, 1'b1, 32'h0040_1003);
        flush_pulse();
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1 i_upd_valid = 1'b0;
            if (!o_busy) break;
            busy_cnt++;
            if (busy_cnt == 3) begin
                i_lookup_pc = 32'h0040_001C;
                #1 check_eq("sweep_lookup", 32'(o_hit), 32'd0);
            end
            if (busy_cnt == 5) begin
                i_upd_valid   = 1'b1;
                i_upd_pc      = 32'h0040_0020;
                i_upd_outcome = TAKEN;
                i_upd_target  = 32'h0040_2000;
            end
        end
        i_upd_valid = 1'b0;
        check_eq("busy_cycles", 32'(busy_cnt), 32'd64);
        for (int i = 0; i < 4; i++) begin
            look("post_sweep", 32'h0040_0010 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
        end
        look("dropped_upd", 32'h0040_0020, 1'b0, 1'b0, 32'h0);
        look("other_entry", 32'h0040_0404, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a sweep
        upd(32'h0040_00FC, TAKEN, 32'h0040_3000);
        look("last_idx", 32'h0040_00FC, 1'b1, 1'b1, 32'h0040_3000);
        flush_pulse();
        repeat (10) @(negedge clk);
        check_eq("mid_sweep_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1 check_eq("reset_busy_now", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        look("after_reset", 32'h0040_00FC, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("idle_after_reset", 32'(o_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
